amr_pingpong_ctrl: RTL

//  Ping-pong sequencer for the banked AMR feature RAM (all banks driven with one shared address).
//  RAM address MSB selects buffer 0/1; each buffer holds one tile of TILE_WORDS words per bank.

---
 rtl/amr_pingpong_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/amr_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : amr_pingpong_ctrl
// Brief    : Ping-pong fill/drain sequencer for the banked AMR feature RAM.
//            Port A fills one buffer while port B streams a tile out of the other.
// Revision : 1.0 - initial release
// ============================================================================
module amr_pingpong_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int TILE_WORDS = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              rd_en,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic              enb,
    output logic              web,
    output logic [ADDR_W-1:0] addrb,
    output logic              out_valid,
    output logic              out_last,
    output logic [1:0]        buf_full
);

    localparam int                 c_CNT_W = ADDR_W - 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TILE_WORDS - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_R_IDLE  = 2'd0;
    localparam logic [1:0] c_R_READ  = 2'd1;
    localparam logic [1:0] c_R_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic               r_wbuf;
    logic               r_rbuf;
    logic [c_CNT_W-1:0] r_wcnt;
    logic [c_CNT_W-1:0] r_rcnt;
    logic [1:0]         r_full;
    logic               r_ena;
    logic [ADDR_W-1:0]  r_addra;
    logic               r_enb;
    logic [ADDR_W-1:0]  r_addrb;
    logic               r_last_iss;
    logic               r_out_valid;
    logic               r_out_last;

    logic               w_accept;
    logic               w_wr_done;
    logic               w_rd_release;
    logic [1:0]         w_full_nxt;

    // rst is folded in so in_ready reads 0 while reset is held
    assign in_ready     = rst & ~r_full[r_wbuf] & ~flush;
    assign w_accept     = in_valid & in_ready;
    assign w_wr_done    = w_accept && (r_wcnt == c_LAST);
    assign w_rd_release = (r_state == c_R_DRAIN);

    // Set and release always target different buffers, so both may apply at once
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) begin
            w_full_nxt[r_wbuf] = 1'b1;
        end
        if (w_rd_release) begin
            w_full_nxt[r_rbuf] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wbuf  <= 1'b0;
            r_wcnt  <= '0;
            r_ena   <= 1'b0;
            r_addra <= '0;
            r_full  <= 2'b00;
        end else if (flush) begin
            r_wbuf  <= 1'b0;
            r_wcnt  <= '0;
            r_ena   <= 1'b0;
            r_addra <= '0;
            r_full  <= 2'b00;
        end else begin
            r_ena  <= w_accept;
            r_full <= w_full_nxt;
            if (w_accept) begin
                r_addra <= {r_wbuf, r_wcnt};
                if (w_wr_done) begin
                    r_wcnt <= '0;
                    r_wbuf <= ~r_wbuf;
                end else begin
                    r_wcnt <= r_wcnt + c_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_R_IDLE;
            r_rbuf      <= 1'b0;
            r_rcnt      <= '0;
            r_enb       <= 1'b0;
            r_addrb     <= '0;
            r_last_iss  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (flush) begin
            r_state     <= c_R_IDLE;
            r_rbuf      <= 1'b0;
            r_rcnt      <= '0;
            r_enb       <= 1'b0;
            r_addrb     <= '0;
            r_last_iss  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            // One-cycle RAM read latency: data qualifiers trail the issue by one edge
            r_out_valid <= r_enb;
            r_out_last  <= r_enb & r_last_iss;
            case (r_state)
                c_R_IDLE: begin
                    r_enb      <= 1'b0;
                    r_last_iss <= 1'b0;
                    if (r_full[r_rbuf] && rd_en) begin
                        r_rcnt  <= '0;
                        r_state <= c_R_READ;
                    end
                end
                c_R_READ: begin
                    r_enb      <= 1'b1;
                    r_addrb    <= {r_rbuf, r_rcnt};
                    r_last_iss <= (r_rcnt == c_LAST);
                    r_rcnt     <= r_rcnt + c_ONE;
                    if (r_rcnt == c_LAST) begin
                        r_state <= c_R_DRAIN;
                    end
                end
                c_R_DRAIN: begin
                    r_enb      <= 1'b0;
                    r_last_iss <= 1'b0;
                    r_rbuf     <= ~r_rbuf;
                    r_state    <= c_R_IDLE;
                end
                default: begin
                    r_enb      <= 1'b0;
                    r_last_iss <= 1'b0;
                    r_state    <= c_R_IDLE;
                end
            endcase
        end
    end

    assign ena       = r_ena;
    assign wea       = r_ena;
    assign addra     = r_addra;
    assign enb       = r_enb;
    assign web       = 1'b0;
    assign addrb     = r_addrb;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign buf_full  = r_full;

endmodule
`default_nettype wire
